dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port, synchronous-read data memory between the core's load/store unit and an external requester (program loader / debug port). Sits between the LSU memory signals and the data memory. Grants one access per cycle, returns read data one cycle later to the correct owner, and stalls the core while it is locked out. Supports bounded locked bursts on the external port.

## Interface
Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width
- MAX_BURST, 8, maximum consecutive locked external beats before forced release (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- core_req  in  1  core access request (load or store)
- core_we  in  1  1 = store, 0 = load
- core_mask  in  4  byte enables
- core_addr  in  AW  byte address
- core_wdata  in  DW  store data
- core_stall  out  1  core must hold PC and request this cycle
- core_rvalid  out  1  core_rdata valid
- core_rdata  out  DW  load data
- ext_req  in  1  external access request
- ext_lock  in  1  hold ownership for following beat
- ext_we, ext_mask, ext_addr, ext_wdata  in  1/4/AW/DW  as core side
- ext_gnt  out  1  external beat accepted this cycle
- ext_rvalid  out  1  ext_rdata valid
- ext_rdata  out  DW  load data
- mem_cs  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_mask  out  4  byte enables
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid cycle after mem_cs with mem_we=0

## Operation
- State: last_owner (CORE/EXT), burst_cnt (clog2(MAX_BURST)+1 bits), resp_pend, resp_owner.
- Grant per cycle, combinational from requests and registered state:
  - One requester active → it wins, except as below.
  - Both active → round-robin: the owner that was not last_owner wins.
  - ext locked: if last_owner=EXT, previous ext beat had ext_lock=1, and burst_cnt < MAX_BURST → EXT wins regardless of core_req.
  - burst_cnt = MAX_BURST → lock ignored; core wins if requesting.
- Winner's fields drive mem_*; mem_cs = core_req | ext_req. No request → mem_cs=0, other mem_* = 0.
- core_stall = core_req & ~core_gnt. ext_gnt = ext_req & ext won.
- Granted load sets resp_pend=1, resp_owner=winner; next cycle mem_rdata routes to that owner with its rvalid=1. Stores produce no rvalid.
- burst_cnt: ext beat granted with ext_lock=1 → +1 (saturating at MAX_BURST); any core grant, or ext beat with ext_lock=0 → 0.
- Unrequested rdata outputs = 0.

## Timing
- Reset values: last_owner=EXT (core wins first contention), burst_cnt=0, resp_pend=0; all rvalid=0, rdata=0, core_stall=0 when core_req=0.
- Grant latency 0 cycles; read latency 1 cycle; one beat/cycle throughput, back-to-back loads pipeline (response of beat N concurrent with grant of N+1).
- Simultaneous first requests after reset → core wins, ext waits exactly one cycle.
- Reset asserted with resp_pend=1 → response dropped, no rvalid next cycle.
- ext_req drops mid-burst → lock released, burst_cnt=0.
- Max core wait: MAX_BURST cycles.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin and burst lock as above.
- Undefined: fixed priority, core always wins contention; ext_lock and burst_cnt ignored (ext granted only when core_req=0); core_stall constant 0.

## Structure
- Package dmem_arb_pkg: owner_e enum {OWN_CORE, OWN_EXT}, default MAX_BURST constant.
- Sub-module dmem_arb_grant: combinational winner selection from requests, last_owner, lock, burst_cnt. Top holds registers and data muxing.

## Test plan
- Core-only load to 0x40, memory returns 0xDEADBEEF → core_rvalid next cycle with 0xDEADBEEF, core_stall=0 throughout.
- Both request every cycle, no lock → grants alternate CORE, EXT, CORE…; core_stall=1 on EXT cycles.
- ext_lock=1 held, MAX_BURST=8, core_req=1 → 8 ext grants, then core granted cycle 9, burst_cnt=0.
- Ext load then core store back-to-back → ext_rvalid in cycle 2 with mem_rdata, core_rvalid stays 0.
- rst in cycle after a granted load → no rvalid, first post-reset contention won by core.
- DMEM_ARB_RR_EN undefined, both requesting 5 cycles → core granted all 5, ext_gnt=0, core_stall=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } owner_e;

  localparam int unsigned MAX_BURST_DEF = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// LSU, external-port and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          core_req;
  logic          core_we;
  logic [3:0]    core_mask;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          ext_req;
  logic          ext_lock;
  logic          ext_we;
  logic [3:0]    ext_mask;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          mem_cs;
  logic          mem_we;
  logic [3:0]    mem_mask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_mask, core_addr, core_wdata,
    output core_stall, core_rvalid, core_rdata,
    input  ext_req, ext_lock, ext_we, ext_mask, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_cs, mem_we, mem_mask, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_mask, core_addr, core_wdata,
    input  core_stall, core_rvalid, core_rdata,
    output ext_req, ext_lock, ext_we, ext_mask, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_cs, mem_we, mem_mask, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_grant.sv
// Combinational winner selection. DMEM_ARB_RR_EN selects round-robin with
// bounded ext lock; otherwise the core has fixed priority.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned CW        = $clog2(MAX_BURST) + 1
) (
  input  logic          core_req,
  input  logic          ext_req,
  input  owner_e        last_owner,
  input  logic [CW-1:0] burst_cnt,
  output logic          core_gnt,
  output logic          ext_gnt
);

`ifdef DMEM_ARB_RR_EN
  logic locked;

  // A non-zero count means the previous ext beat asked to keep the bus.
  always_comb begin
    locked   = (last_owner == OWN_EXT) && (burst_cnt != '0) &&
               (burst_cnt < CW'(MAX_BURST));
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (ext_req && (locked || !core_req || last_owner == OWN_CORE))
      ext_gnt = 1'b1;
    else if (core_req)
      core_gnt = 1'b1;
  end
`else
  logic unused_state;

  assign unused_state = ^{last_owner, burst_cnt};
  assign core_gnt     = core_req;
  assign ext_gnt      = ext_req & ~core_req;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port sync-read data memory between LSU and external port.
// Build option DMEM_ARB_RR_EN: round-robin with locked ext bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  owner_e        last_owner;
  logic [CW-1:0] burst_cnt;
  logic          resp_pend;
  owner_e        resp_owner;
  logic          core_gnt;
  logic          ext_gnt;
  logic          resp_live;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CW'(MAX_BURST)) ? v : v + 1'b1;
  endfunction

  dmem_arb_grant #(
    .MAX_BURST(MAX_BURST),
    .CW       (CW)
  ) u_grant (
    .core_req  (bus.core_req),
    .ext_req   (bus.ext_req),
    .last_owner(last_owner),
    .burst_cnt (burst_cnt),
    .core_gnt  (core_gnt),
    .ext_gnt   (ext_gnt)
  );

  // Stage 0: winner drives the memory port in the request cycle.
  always_comb begin
    bus.mem_cs    = bus.core_req | bus.ext_req;
    bus.mem_we    = 1'b0;
    bus.mem_mask  = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (core_gnt) begin
      bus.mem_we    = bus.core_we;
      bus.mem_mask  = bus.core_mask;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end else if (ext_gnt) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_mask  = bus.ext_mask;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

`ifdef DMEM_ARB_RR_EN
  assign bus.core_stall = bus.core_req & ~core_gnt;
`else
  assign bus.core_stall = 1'b0;
`endif
  assign bus.ext_gnt = ext_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_EXT;
      burst_cnt  <= '0;
      resp_pend  <= 1'b0;
      resp_owner <= OWN_CORE;
    end else begin
      resp_pend  <= (core_gnt & ~bus.core_we) | (ext_gnt & ~bus.ext_we);
      resp_owner <= ext_gnt ? OWN_EXT : OWN_CORE;
      if (core_gnt)
        last_owner <= OWN_CORE;
      else if (ext_gnt)
        last_owner <= OWN_EXT;
      burst_cnt <= (ext_gnt && bus.ext_lock) ? sat_inc(burst_cnt) : '0;
    end
  end

  // Stage 1: memory data returns to the owner of last cycle's load; a
  // response still pending while reset is asserted is discarded.
  assign resp_live       = resp_pend & ~rst;
  assign bus.core_rvalid = resp_live & (resp_owner == OWN_CORE);
  assign bus.ext_rvalid  = resp_live & (resp_owner == OWN_EXT);
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
  assign bus.ext_rdata   = bus.ext_rvalid  ? bus.mem_rdata : '0;

endmodule
